// File: rtl/mem_arb_if.sv
// Handshake bundle shared by the fetch port, the data port and the memory port of mem_arb.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arb_if #(
    parameter int unsigned AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [1:0]    dm_op;
    logic          dm_ext;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_ack;
    logic [31:0]   dm_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    logic          err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_op, dm_ext, dm_addr, dm_wdata,
               mem_ack, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_op, dm_ext, dm_addr, dm_wdata,
               mem_ack, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port (fetch / data) round-robin arbiter onto one 32-bit memory port with store lane
// replication and load extraction. Optional memory-wait timeout under MEM_ARB_TIMEOUT_EN.
module mem_arb #(
    parameter int unsigned AW        = 32,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rstn,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DONE
    } state_t;

    state_t        r_state;
    logic          r_last_dm;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [3:0]    r_mem_be;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_if_ack;
    logic          r_dm_ack;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;
    logic [1:0]    r_op;
    logic          r_ext;
    logic [1:0]    r_lo;

    logic          w_gnt_dm;
    logic          w_gnt_if;
    logic [3:0]    w_st_be;
    logic [31:0]   w_st_wdata;
    logic [7:0]    w_ld_byte;
    logic [15:0]   w_ld_half;
    logic [31:0]   w_ld_data;
    logic          w_timeout;
    logic          w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.if_addr[1:0]};

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_gnt_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
        w_gnt_if = bus.if_req && !w_gnt_dm;
    end

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.dm_wdata;
        case (bus.dm_op)
            2'd1: begin
                w_st_be    = bus.dm_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{bus.dm_wdata[15:0]}};
            end
            2'd2: begin
                w_st_be    = 4'b0001 << bus.dm_addr[1:0];
                w_st_wdata = {4{bus.dm_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = bus.mem_rdata[{r_lo, 3'b000} +: 8];
        w_ld_half = r_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_op)
            2'd1:    w_ld_data = {{16{r_ext & w_ld_half[15]}}, w_ld_half};
            2'd2:    w_ld_data = {{24{r_ext & w_ld_byte[7]}}, w_ld_byte};
            default: w_ld_data = bus.mem_rdata;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYCLES) + 1;

    logic [CW-1:0] r_to_cnt;
    logic          r_err;

    // The counter holds the number of BUSY cycles already elapsed before the current one.
    assign w_timeout = (r_state == BUSY_IF || r_state == BUSY_DM) && !bus.mem_ack &&
                       (r_to_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == BUSY_IF || r_state == BUSY_DM) && !bus.mem_ack && !w_timeout)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    localparam int unsigned UNUSED_TO_CYCLES = TO_CYCLES;

    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_last_dm   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_op        <= '0;
            r_ext       <= 1'b0;
            r_lo        <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_dm) begin
                        r_state     <= BUSY_DM;
                        r_last_dm   <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.dm_we;
                        r_mem_addr  <= {bus.dm_addr[AW-1:2], 2'b00};
                        r_mem_be    <= bus.dm_we ? w_st_be : 4'b1111;
                        r_mem_wdata <= bus.dm_we ? w_st_wdata : '0;
                        r_op        <= bus.dm_op;
                        r_ext       <= bus.dm_ext;
                        r_lo        <= bus.dm_addr[1:0];
                    end else if (w_gnt_if) begin
                        r_state     <= BUSY_IF;
                        r_last_dm   <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {bus.if_addr[AW-1:2], 2'b00};
                        r_mem_be    <= 4'b1111;
                        r_mem_wdata <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // Ack pulse and rdata update land together in the DONE cycle.
                    if (bus.mem_ack || w_timeout) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        if (r_state == BUSY_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_timeout ? '0 : bus.mem_rdata;
                        end else begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= w_timeout ? '0 : w_ld_data;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of data-port vectors plus hand sequences for arbitration,
// slow memory, dropped requests, reset abort and (with MEM_ARB_TIMEOUT_EN) the timeout path.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mem_arb_if #(.AW(32)) bus ();

    mem_arb #(.AW(32), .TO_CYCLES(16)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] maddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[16];

    int total = 0;
    int bad   = 0;

    // Memory model controls
    int unsigned mem_lat     = 0;
    bit          mem_never   = 1'b0;
    bit          mem_force   = 1'b0;
    logic [31:0] mem_rdata_v = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: acks mem_lat cycles after mem_req is first seen.
    initial begin
        int unsigned wait_cnt;
        wait_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = mem_rdata_v;
            if (mem_force) begin
                bus.mem_ack = 1'b1;
            end else if (!rstn || !bus.mem_req || mem_never) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (wait_cnt >= mem_lat) begin
                bus.mem_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic dm_txn(input vec_t v, input int idx);
        int n;
        mem_rdata_v  = v.mrdata;
        bus.dm_we    = v.we;
        bus.dm_op    = v.op;
        bus.dm_ext   = v.ext;
        bus.dm_addr  = v.addr;
        bus.dm_wdata = v.wdata;
        bus.dm_req   = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d mem_req", idx), 32'(bus.mem_req), 32'd1);
        chk($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.we));
        chk($sformatf("v%0d mem_be", idx), 32'(bus.mem_be), 32'(v.be));
        chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.maddr);
        if (v.we) chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.mwdata);
        n = 0;
        while (!bus.dm_ack && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d dm_ack", idx), 32'(bus.dm_ack), 32'd1);
        chk($sformatf("v%0d if_ack", idx), 32'(bus.if_ack), 32'd0);
        if (!v.we) chk($sformatf("v%0d dm_rdata", idx), bus.dm_rdata, v.rdata);
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ack pulse", idx), 32'(bus.dm_ack), 32'd0);
    endtask

    initial begin
        int         cyc;
        int         na;
        int         first_req;
        int         both_cnt;
        int         cnt_a;
        int         cnt_b;
        int         cnt_c;
        int         cnt_d;
        logic       prev_req;
        logic       ack_is_dm[4];
        int         ack_cyc[4];
        logic [31:0] addrs[$];
        logic [3:0]  snap_be;
        logic [31:0] snap_addr;
        logic [31:0] snap_wdata;
        logic        snap_we;
        logic        snap_ok;

        vecs[0]  = '{1'b0, 2'd2, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h100, 32'hFFFFFF80};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h100, 32'h00000080};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h22,  32'h0000BEEF, 32'h0,        4'hC, 32'hBEEFBEEF, 32'h20,  32'h0};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h41,  32'h123456A5, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h40,  32'h0};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 32'h10,  32'h0};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 32'h8,   32'h01020304, 32'h0,        4'hF, 32'h01020304, 32'h8,   32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        32'h9ABC1234, 4'hF, 32'h0,        32'h200, 32'hFFFF9ABC};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h203, 32'h0,        32'h9ABC1234, 4'hF, 32'h0,        32'h200, 32'h00009ABC};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h200, 32'h0,        32'h9ABC7234, 4'hF, 32'h0,        32'h200, 32'h00007234};
        vecs[9]  = '{1'b0, 2'd2, 1'b1, 32'h101, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h100, 32'h00000012};
        vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h102, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h100, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h302, 32'h0,        32'h87654321, 4'hF, 32'h0,        32'h300, 32'h87654321};
        vecs[12] = '{1'b0, 2'd3, 1'b1, 32'h304, 32'h0,        32'hF0000001, 4'hF, 32'h0,        32'h304, 32'hF0000001};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h43,  32'h000000C3, 32'h0,        4'h8, 32'hC3C3C3C3, 32'h40,  32'h0};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h21,  32'hFFFF5A5A, 32'h0,        4'h3, 32'h5A5A5A5A, 32'h20,  32'h0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h80FF1234, 4'hF, 32'h0,        32'h100, 32'h00000034};

        rstn         = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_op    = '0;
        bus.dm_ext   = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
        chk("rst if_rdata", bus.if_rdata, 32'd0);
        chk("rst dm_rdata", bus.dm_rdata, 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        rstn = 1'b1;

        // Both requesters held from reset: DM, IF, DM, IF, acks 3 cycles apart
        mem_rdata_v = 32'hCAFEF00D;
        bus.dm_we   = 1'b0;
        bus.dm_op   = 2'd0;
        bus.dm_addr = 32'h500;
        bus.if_addr = 32'h1006;
        bus.dm_req  = 1'b1;
        bus.if_req  = 1'b1;
        cyc = 0; na = 0; first_req = -1; both_cnt = 0; prev_req = 1'b0;
        while (na < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req && !prev_req) begin
                addrs.push_back(bus.mem_addr);
                if (first_req < 0) first_req = cyc;
            end
            prev_req = bus.mem_req;
            if (bus.dm_ack && bus.if_ack) both_cnt++;
            if (bus.dm_ack || bus.if_ack) begin
                ack_is_dm[na] = bus.dm_ack;
                ack_cyc[na]   = cyc;
                if (bus.if_ack) chk("alt if_rdata", bus.if_rdata, 32'hCAFEF00D);
                else            chk("alt dm_rdata", bus.dm_rdata, 32'hCAFEF00D);
                na++;
            end
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        chk("alt ack count", 32'(na), 32'd4);
        chk("alt first mem_req cycle", 32'(first_req), 32'd1);
        chk("alt both acks", 32'(both_cnt), 32'd0);
        chk("alt grant count", 32'(addrs.size()), 32'd4);
        for (int i = 0; i < na; i++) begin
            chk($sformatf("alt order %0d", i), 32'(ack_is_dm[i]), 32'((i % 2) == 0));
            if (i > 0) chk($sformatf("alt spacing %0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        for (int i = 0; i < addrs.size() && i < 4; i++)
            chk($sformatf("alt addr %0d", i), addrs[i], ((i % 2) == 0) ? 32'h500 : 32'h1004);
        @(negedge clk);

        // Data-port vector table
        for (int i = 0; i < 16; i++) dm_txn(vecs[i], i);

        // Slow memory: outputs stable, one ack, one grant
        mem_lat      = 5;
        bus.dm_we    = 1'b1;
        bus.dm_op    = 2'd2;
        bus.dm_addr  = 32'h77;
        bus.dm_wdata = 32'h0000005A;
        bus.dm_req   = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; prev_req = 1'b0;
        snap_ok = 1'b0; snap_be = '0; snap_addr = '0; snap_wdata = '0; snap_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                cnt_a++;
                if (!prev_req) begin
                    cnt_d++;
                    if (!snap_ok) begin
                        snap_ok = 1'b1; snap_be = bus.mem_be; snap_addr = bus.mem_addr;
                        snap_wdata = bus.mem_wdata; snap_we = bus.mem_we;
                    end
                end else if (bus.mem_be !== snap_be || bus.mem_addr !== snap_addr ||
                             bus.mem_wdata !== snap_wdata || bus.mem_we !== snap_we) begin
                    cnt_b++;
                end
            end
            prev_req = bus.mem_req;
            if (bus.dm_ack) begin
                cnt_c++;
                bus.dm_req = 1'b0;
            end
        end
        bus.dm_req = 1'b0;
        mem_lat    = 0;
        chk("slow mem_req cycles", 32'(cnt_a), 32'd6);
        chk("slow unstable cycles", 32'(cnt_b), 32'd0);
        chk("slow dm_ack pulses", 32'(cnt_c), 32'd1);
        chk("slow grants", 32'(cnt_d), 32'd1);
        chk("slow mem_be", 32'(snap_be), 32'h8);
        chk("slow mem_addr", snap_addr, 32'h74);
        chk("slow mem_wdata", snap_wdata, 32'h5A5A5A5A);

        // Fetch request dropped after grant still completes
        mem_lat     = 2;
        mem_rdata_v = 32'h11223344;
        bus.if_addr = 32'h2003;
        bus.if_req  = 1'b1;
        @(negedge clk);
        chk("drop mem_req", 32'(bus.mem_req), 32'd1);
        chk("drop mem_addr", bus.mem_addr, 32'h2000);
        chk("drop mem_we", 32'(bus.mem_we), 32'd0);
        chk("drop mem_be", 32'(bus.mem_be), 32'hF);
        bus.if_req = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                cnt_a++;
                chk("drop if_rdata", bus.if_rdata, 32'h11223344);
            end
            if (bus.dm_ack) cnt_b++;
        end
        chk("drop if_ack pulses", 32'(cnt_a), 32'd1);
        chk("drop stray dm_ack", 32'(cnt_b), 32'd0);
        mem_lat = 0;

        // mem_ack while idle is ignored
        mem_force = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack || bus.mem_req) cnt_a++;
        end
        mem_force = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle ack ignored", 32'(cnt_a), 32'd0);
        dm_txn(vecs[6], 100);

        // Reset during BUSY_IF abandons the fetch
        mem_never   = 1'b1;
        bus.if_addr = 32'h3000;
        bus.if_req  = 1'b1;
        @(negedge clk);
        chk("rstbusy mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rstbusy mem_req async", 32'(bus.mem_req), 32'd0);
        chk("rstbusy dm_rdata", bus.dm_rdata, 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        mem_never = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.if_ack) cnt_a++;
        end
        chk("rstbusy no if_ack", 32'(cnt_a), 32'd0);
        mem_rdata_v = 32'h0BADF00D;
        bus.if_addr = 32'h3008;
        bus.if_req  = 1'b1;
        cnt_a = 0;
        while (!bus.if_ack && cnt_a < 20) begin
            @(negedge clk);
            cnt_a++;
        end
        bus.if_req = 1'b0;
        chk("refetch if_ack", 32'(bus.if_ack), 32'd1);
        chk("refetch if_rdata", bus.if_rdata, 32'h0BADF00D);
        @(negedge clk);

        // Memory that never answers
        dm_txn(vecs[0], 200);
        mem_never    = 1'b1;
        mem_rdata_v  = 32'h12345678;
        bus.dm_we    = 1'b0;
        bus.dm_op    = 2'd0;
        bus.dm_addr  = 32'h600;
        bus.dm_req   = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_a = 0; cnt_b = 0;
        while (!bus.dm_ack && cnt_b < 40) begin
            @(negedge clk);
            cnt_b++;
            if (bus.mem_req) cnt_a++;
        end
        bus.dm_req = 1'b0;
        chk("to dm_ack", 32'(bus.dm_ack), 32'd1);
        chk("to mem_req cycles", 32'(cnt_a), 32'd16);
        chk("to dm_rdata", bus.dm_rdata, 32'd0);
        chk("to err", 32'(bus.err), 32'd1);
        mem_never = 1'b0;
        @(negedge clk);
        dm_txn(vecs[1], 300);
        chk("to err sticky", 32'(bus.err), 32'd1);
        do_reset();
        chk("to err cleared", 32'(bus.err), 32'd0);
`else
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.dm_ack) cnt_a++;
            if (bus.err) cnt_b++;
        end
        chk("wait mem_req held", 32'(bus.mem_req), 32'd1);
        chk("wait no dm_ack", 32'(cnt_a), 32'd0);
        chk("wait err low", 32'(cnt_b), 32'd0);
        bus.dm_req = 1'b0;
        mem_never  = 1'b0;
        do_reset();
        chk("wait mem_req after reset", 32'(bus.mem_req), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width of all address ports.
REQ-002 The block SHALL have parameter TO_CYCLES, default 16, meaning the memory-wait limit used only under MEM_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held with stable if_addr until if_ack.
REQ-006 if_addr  input  AW  fetch byte address; bits [1:0] ignored.
REQ-007 if_ack  output  1  one-cycle completion pulse for fetch.
REQ-008 if_rdata  output  32  fetched word; valid in the if_ack cycle and held until the next if_ack.
REQ-009 dm_req  input  1  data request; held with stable dm_* fields until dm_ack.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_op  input  2  access size: 0 = word, 1 = half, 2 = byte, 3 = word.
REQ-012 dm_ext  input  1  load extension: 1 = sign, 0 = zero.
REQ-013 dm_addr  input  AW  data byte address.
REQ-014 dm_wdata  input  32  store data, right-aligned.
REQ-015 dm_ack  output  1  one-cycle completion pulse for data.
REQ-016 dm_rdata  output  32  extended load result; valid in the dm_ack cycle and held until the next dm_ack.
REQ-017 mem_req  output  1  memory request; held until mem_ack.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_be  output  4  byte enables; bit i = byte lane i (little-endian).
REQ-020 mem_addr  output  AW  word-aligned address; bits [1:0] = 0.
REQ-021 mem_wdata  output  32  lane-replicated write data.
REQ-022 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-023 mem_rdata  input  32  memory read word.
REQ-024 err  output  1  sticky timeout flag.

Function
REQ-025 The state machine SHALL have the states IDLE, BUSY_IF, BUSY_DM and DONE.
REQ-026 IDLE: a lone request SHALL be granted; if both are pending, the requester not granted last SHALL win (a last_dm bit is updated on each grant).
REQ-027 On a grant the block SHALL register mem_addr, mem_we, mem_be and mem_wdata, and SHALL assert mem_req from the next cycle (request sampled at edge N gives mem_req high in cycle N+1).
REQ-028 In BUSY_* all mem_* outputs SHALL stay stable until the cycle mem_ack=1, when the block captures mem_rdata and moves to DONE.
REQ-029 DONE: the block SHALL pulse the granted ack with its rdata for one cycle, SHALL not pulse the other ack, and SHALL go to IDLE; the minimum transaction is 3 cycles.
REQ-030 Requests SHALL not be sampled in BUSY_* or DONE.
REQ-031 A req dropped mid-transaction SHALL be ignored: the transaction completes and the ack still pulses.
REQ-032 Fetch SHALL drive mem_we=0 and mem_be=4'b1111, and if_rdata = mem_rdata unmodified.
REQ-033 Data loads SHALL drive mem_we=0 and mem_be=4'b1111.
REQ-034 Word stores SHALL drive mem_be=4'b1111.
REQ-035 Half stores SHALL drive mem_be=4'b0011<<(2*addr[1]) and mem_wdata={2{wdata[15:0]}}.
REQ-036 Byte stores SHALL drive mem_be=4'b0001<<addr[1:0] and mem_wdata={4{wdata[7:0]}}.
REQ-037 Loads SHALL select the byte lane by addr[1:0] or the half by addr[1], then sign-extend or zero-extend according to dm_ext; word loads SHALL pass the word unchanged.
REQ-038 Misaligned addresses SHALL be silently truncated (half ignores addr[0], word ignores addr[1:0]); no error is raised.
REQ-039 mem_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-040 rstn low SHALL immediately (asynchronously) force IDLE, last_dm=0, all outputs 0 (including rdata registers and err) and any timeout counter to 0, abandoning any in-flight transaction without an ack.
REQ-041 After reset, the first simultaneous request SHALL be granted to DM.

Configuration
REQ-042 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count BUSY_* cycles; if it reaches TO_CYCLES without mem_ack, the block SHALL drop mem_req, go to DONE, pulse the requester's ack with rdata=32'h0, and set err until reset.
REQ-043 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait for mem_ack indefinitely, SHALL omit the counter, and SHALL tie err to 0.

Verification
REQ-044 if_req=1 and dm_req=1 held after reset, memory acks immediately -> DM granted first, then IF, then DM alternating; mem_req rises one cycle after the request.
REQ-045 DM load, dm_op=2, dm_ext=1, addr=0x103, mem_rdata=0x80FF1234 -> dm_rdata=0xFFFFFF80; with dm_ext=0 -> 0x00000080.
REQ-046 DM store, dm_op=1, addr=0x22, wdata=0x0000BEEF -> mem_be=4'b1100, mem_wdata=0xBEEFBEEF, mem_addr=0x20.
REQ-047 mem_ack delayed 5 cycles -> mem_* outputs stable throughout, exactly one ack pulse, no second grant.
REQ-048 rstn pulsed low during BUSY_IF -> mem_req drops the same cycle, no if_ack, and the next fetch completes normally.
REQ-049 MEM_ARB_TIMEOUT_EN defined, TO_CYCLES=16, mem_ack never asserted -> mem_req drops after 16 cycles, dm_ack pulses with dm_rdata=0, err=1 and sticky.
